// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch port between the sequencer and instruction memory.
// The sequencer owns req/addr; memory answers with ack/rdata.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit core.
// Owns IR, PC, NZP condition codes and the retired-instruction counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | halted; waits for run at an instruction boundary
//   S_FETCH  | imem_req held with addr=pc until imem_ack
//   S_DECODE | one settle cycle for decoder and datapath
//   S_EXEC   | branch resolve / retire, or hand off to writeback
//   S_WB     | rf_we strobe, CC update, retire (reported as EXEC)
module cpu_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h3000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    cpu_sequencer_if.master     imem,
    output logic [15:0]         ir,
    input  logic                dec_we_reg,
    input  logic                dec_branch,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic [15:0]         wb_data,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   pc,
    output logic [2:0]          cc,
    output logic [1:0]          state,
    output logic [15:0]         retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } seq_state_t;

    seq_state_t cur_st;
    seq_state_t nxt_st;
    logic       imem_req_c;
    logic       rf_we_c;
    logic       taken;

    // JMP (opcode 1100) is unconditional; BR tests its nzp mask against cc.
    assign taken = (ir[15:12] == 4'b1100) | (|(ir[11:9] & cc));

    always_comb begin
        nxt_st     = cur_st;
        imem_req_c = 1'b0;
        rf_we_c    = 1'b0;
        case (cur_st)
            S_IDLE: begin
                if (run) nxt_st = S_FETCH;
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem.imem_ack) nxt_st = S_DECODE;
            end
            S_DECODE: begin
                nxt_st = S_EXEC;
            end
            S_EXEC: begin
                if (!dec_branch && dec_we_reg) nxt_st = S_WB;
                else                           nxt_st = run ? S_FETCH : S_IDLE;
            end
            S_WB: begin
                rf_we_c = 1'b1;
                nxt_st  = run ? S_FETCH : S_IDLE;
            end
            default: nxt_st = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st  <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= 16'h0000;
            cc      <= 3'b010;
            retired <= 16'h0000;
        end else begin
            cur_st <= nxt_st;
            case (cur_st)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        ir <= imem.imem_rdata;
                        pc <= pc + 1'b1;
                    end
                end
                S_EXEC: begin
                    // Branch wins over a simultaneous register write.
                    if (dec_branch) begin
                        if (taken) pc <= branch_target;
                        retired <= retired + 16'd1;
                    end else if (!dec_we_reg) begin
                        retired <= retired + 16'd1;
                    end
                end
                S_WB: begin
                    if (wb_data[15])           cc <= 3'b100;
                    else if (wb_data == 16'd0) cc <= 3'b010;
                    else                       cc <= 3'b001;
                    retired <= retired + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (cur_st)
            S_IDLE:   state = 2'd0;
            S_FETCH:  state = 2'd1;
            S_DECODE: state = 2'd2;
            default:  state = 2'd3;
        endcase
    end

    assign imem.imem_req  = imem_req_c;
    assign imem.imem_addr = pc;
    assign rf_we          = rf_we_c;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the bench plays instruction memory and
// decoder, and checks PC/CC/IR/retired and strobe timing against hand values.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] ir;
    logic        dec_we_reg;
    logic        dec_branch;
    logic [15:0] branch_target;
    logic [15:0] wb_data;
    logic        rf_we;
    logic [15:0] pc;
    logic [2:0]  cc;
    logic [1:0]  state;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_sequencer_if #(.ADDR_W(16)) imem_bus ();

    cpu_sequencer #(.ADDR_W(16), .RESET_PC(16'h3000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .imem          (imem_bus.master),
        .ir            (ir),
        .dec_we_reg    (dec_we_reg),
        .dec_branch    (dec_branch),
        .branch_target (branch_target),
        .wb_data       (wb_data),
        .rf_we         (rf_we),
        .pc            (pc),
        .cc            (cc),
        .state         (state),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH at fetch_addr; leaves at the
    // negedge after the instruction retires (next FETCH, or IDLE if run dropped).
    task automatic exec_instr(input string tag, input logic [15:0] word, input int delay,
                              input logic we, input logic br, input logic [15:0] tgt,
                              input logic [15:0] wbd, input logic keep_run,
                              input logic [15:0] fetch_addr, input logic [15:0] exp_pc,
                              input logic [2:0] exp_cc);
        logic [15:0] pc_inc;
        pc_inc = fetch_addr + 16'd1;
        chk({tag, ".fetch_state"}, 32'(state), 32'd1);
        chk({tag, ".fetch_req"}, 32'(imem_bus.imem_req), 32'd1);
        chk({tag, ".fetch_addr"}, 32'(imem_bus.imem_addr), 32'(fetch_addr));
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, ".wait_addr"}, 32'(imem_bus.imem_addr), 32'(fetch_addr));
            chk({tag, ".wait_req"}, 32'(imem_bus.imem_req), 32'd1);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        dec_we_reg          = we;
        dec_branch          = br;
        branch_target       = tgt;
        wb_data             = wbd;
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        chk({tag, ".dec_state"}, 32'(state), 32'd2);
        chk({tag, ".ir"}, 32'(ir), 32'(word));
        chk({tag, ".pc_inc"}, 32'(pc), 32'(pc_inc));
        chk({tag, ".dec_req"}, 32'(imem_bus.imem_req), 32'd0);
        run = keep_run;
        @(negedge clk);
        chk({tag, ".exec_state"}, 32'(state), 32'd3);
        chk({tag, ".exec_rfwe"}, 32'(rf_we), 32'd0);
        if (we && !br) begin
            @(negedge clk);
            chk({tag, ".wb_state"}, 32'(state), 32'd3);
            chk({tag, ".wb_rfwe"}, 32'(rf_we), 32'd1);
        end
        @(negedge clk);
        chk({tag, ".next_state"}, 32'(state), keep_run ? 32'd1 : 32'd0);
        chk({tag, ".next_req"}, 32'(imem_bus.imem_req), 32'(keep_run));
        chk({tag, ".rfwe_off"}, 32'(rf_we), 32'd0);
        chk({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, ".cc"}, 32'(cc), 32'(exp_cc));
        dec_we_reg = 1'b0;
        dec_branch = 1'b0;
    endtask

    initial begin
        rst_n               = 1'b0;
        run                 = 1'b1;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 16'h0000;
        dec_we_reg          = 1'b0;
        dec_branch          = 1'b0;
        branch_target       = 16'h0000;
        wb_data             = 16'h0000;

        // Reset held for two edges with run=1
        repeat (2) @(negedge clk);
        chk("rst.pc", 32'(pc), 32'h3000);
        chk("rst.cc", 32'(cc), 32'd2);
        chk("rst.ir", 32'(ir), 32'd0);
        chk("rst.retired", 32'(retired), 32'd0);
        chk("rst.req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.rfwe", 32'(rf_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with a slow ack, negative result
        exec_instr("add", 16'h1042, 3, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 1'b1,
                   16'h3000, 16'h3001, 3'b100);
        chk("add.retired", 32'(retired), 32'd1);

        // Zero result -> cc=Z, then BRz taken, BRnp not taken
        exec_instr("wbz", 16'h1020, 0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1,
                   16'h3001, 16'h3002, 3'b010);
        exec_instr("brz", 16'h0405, 1, 1'b0, 1'b1, 16'h3010, 16'h0000, 1'b1,
                   16'h3002, 16'h3010, 3'b010);
        exec_instr("brnp", 16'h0A05, 0, 1'b0, 1'b1, 16'h4444, 16'h0000, 1'b1,
                   16'h3010, 16'h3011, 3'b010);

        // Positive result -> cc=P, JMP regardless of cc, BR nzp=000 never taken
        exec_instr("wbp", 16'h1025, 0, 1'b1, 1'b0, 16'h0000, 16'h0005, 1'b1,
                   16'h3011, 16'h3012, 3'b001);
        exec_instr("jmp", 16'hC080, 2, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b1,
                   16'h3012, 16'h1234, 3'b001);
        exec_instr("brnop", 16'h0000, 0, 1'b0, 1'b1, 16'h5555, 16'h0000, 1'b1,
                   16'h1234, 16'h1235, 3'b001);

        // Both decoder flags: branch wins, no writeback, cc untouched
        exec_instr("prio", 16'hC080, 0, 1'b1, 1'b1, 16'hFFFF, 16'h8000, 1'b1,
                   16'h1235, 16'hFFFF, 3'b001);
        chk("prio.retired", 32'(retired), 32'd8);

        // NOP at FFFF wraps pc; run dropped in DECODE ends in IDLE
        exec_instr("wrap", 16'h5000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                   16'hFFFF, 16'h0000, 3'b001);
        chk("wrap.retired", 32'(retired), 32'd9);
        repeat (3) @(negedge clk);
        chk("idle.state", 32'(state), 32'd0);
        chk("idle.req", 32'(imem_bus.imem_req), 32'd0);
        chk("idle.retired", 32'(retired), 32'd9);

        // Reset during a pending fetch with ack in the same cycle
        run = 1'b1;
        @(negedge clk);
        chk("rf.state", 32'(state), 32'd1);
        chk("rf.addr", 32'(imem_bus.imem_addr), 32'h0000);
        rst_n               = 1'b0;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 16'hBEEF;
        run                 = 1'b0;
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        chk("rf.ir", 32'(ir), 32'd0);
        chk("rf.pc", 32'(pc), 32'h3000);
        chk("rf.state_idle", 32'(state), 32'd0);
        chk("rf.cc", 32'(cc), 32'd2);
        chk("rf.retired", 32'(retired), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rf.stay_idle", 32'(state), 32'd0);
        chk("rf.no_req", 32'(imem_bus.imem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
